// File: rtl/vga_timing_checker.sv
// VGA sync/colour stream monitor: measures hsync/vsync timing and blanking against a
// programmed mode, reports lock, sticky error flags and a count of clean frames.
module vga_timing_checker #(
  parameter int H_VISIBLE = 800,
  parameter int H_FRONT   = 40,
  parameter int H_SYNC    = 128,
  parameter int H_BACK    = 88,
  parameter int V_VISIBLE = 600,
  parameter int V_FRONT   = 1,
  parameter int V_SYNC    = 4,
  parameter int V_BACK    = 23,
  parameter int H_POL     = 1,
  parameter int V_POL     = 1,
  parameter int COLOR_W   = 1
) (
  input  logic               clock,
  input  logic               reset_button,
  input  logic               h_sync,
  input  logic               v_sync,
  input  logic [COLOR_W-1:0] color_r,
  input  logic [COLOR_W-1:0] color_g,
  input  logic [COLOR_W-1:0] color_b,
  input  logic               clear,
  output logic               locked,
  output logic               err_hperiod,
  output logic               err_hwidth,
  output logic               err_vperiod,
  output logic               err_vwidth,
  output logic               err_blank,
  output logic               err_pulse,
  output logic [15:0]        frame_count,
  output logic [1:0]         dbg_state
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);

  localparam logic H_ACT = (H_POL != 0);
  localparam logic V_ACT = (V_POL != 0);

  localparam logic [HW-1:0] H_MAX       = HW'(H_TOTAL);
  localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_LAST = HW'(H_SYNC - 1);
  localparam logic [HW-1:0] H_ACT_LO    = HW'(H_SYNC + H_BACK);
  localparam logic [HW-1:0] H_ACT_HI    = HW'(H_SYNC + H_BACK + H_VISIBLE - 1);
  localparam logic [VW-1:0] V_MAX       = VW'(V_TOTAL);
  localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_END  = VW'(V_SYNC);
  localparam logic [VW-1:0] V_ACT_LO    = VW'(V_SYNC + V_BACK);
  localparam logic [VW-1:0] V_ACT_HI    = VW'(V_SYNC + V_BACK + V_VISIBLE - 1);

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    TRACK   = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic                   hs_s1_q, hs_s2_q, vs_s1_q, v_samp_q;
  logic [3*COLOR_W-1:0]   col_s1_q, col_s2_q;
  logic [HW-1:0]          h_pos_q, h_pos_d;
  logic [VW-1:0]          v_line_q, v_line_d;
  logic [3:0]             sync_err_q, sync_err_d;
  logic                   ve_q;
  logic [4:0]             flags_q, flags_d, err_vec;
  logic                   err_pulse_q;
  logic [15:0]            frame_cnt_q, frame_cnt_d;
  logic                   he, hx, v_act, ve, vx;
  logic                   in_active, blank_err, any_err, fc_inc;

  assign he    = (hs_s1_q == H_ACT) && (hs_s2_q != H_ACT);
  assign hx    = (hs_s1_q != H_ACT) && (hs_s2_q == H_ACT);
  assign v_act = (vs_s1_q == V_ACT);
  assign ve    = he && v_act && !v_samp_q;
  assign vx    = he && !v_act && v_samp_q;

  always_comb begin
    h_pos_d = h_pos_q;
    if (he) begin
      h_pos_d = '0;
    end else if (h_pos_q != H_MAX) begin
      h_pos_d = h_pos_q + 1'b1;
    end
    v_line_d = v_line_q;
    if (ve) begin
      v_line_d = '0;
    end else if (he && (v_line_q != V_MAX)) begin
      v_line_d = v_line_q + 1'b1;
    end
  end

  // Sync checks are raw here and registered once, so they meet the state one cycle
  // later, lined up with the blank check, which looks at the s2 colour directly.
  always_comb begin
    sync_err_d    = '0;
    sync_err_d[0] = (he && (h_pos_q != H_LAST)) || (!he && (h_pos_q == H_LAST));
    sync_err_d[1] = hx && (h_pos_q != H_SYNC_LAST);
    sync_err_d[2] = (ve && (v_line_q != V_LAST)) || (he && !ve && (v_line_q == V_LAST));
    // Vsync width is judged on the line number this HE moves v_line to.
    sync_err_d[3] = vx && (v_line_d != V_SYNC_END);
  end

  assign in_active = (h_pos_q >= H_ACT_LO) && (h_pos_q <= H_ACT_HI) &&
                     (v_line_q >= V_ACT_LO) && (v_line_q <= V_ACT_HI);
  assign blank_err = !in_active && (|col_s2_q);

  // Bit order: 0 hperiod, 1 hwidth, 2 vperiod, 3 vwidth, 4 blank.
  assign err_vec = (state_q != ACQUIRE) ? {blank_err, sync_err_q} : 5'b0;
  assign any_err = |err_vec;

  always_comb begin
    state_d = state_q;
    fc_inc  = 1'b0;
    case (state_q)
      ACQUIRE: if (ve_q) state_d = TRACK;
      TRACK: begin
        if (any_err)   state_d = ACQUIRE;
        else if (ve_q) state_d = LOCKED;
      end
      LOCKED: begin
        if (any_err)   state_d = ACQUIRE;
        else if (ve_q) fc_inc = 1'b1;
      end
      default: state_d = ACQUIRE;
    endcase
  end

  always_comb begin
    flags_d     = (clear ? 5'b0 : flags_q) | err_vec;
    frame_cnt_d = frame_cnt_q;
    if (clear) begin
      frame_cnt_d = '0;
    end else if (fc_inc && (frame_cnt_q != 16'hFFFF)) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_button) begin
    if (!reset_button) begin
      state_q <= ACQUIRE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or negedge reset_button) begin
    if (!reset_button) begin
      hs_s1_q     <= 1'b0;
      hs_s2_q     <= 1'b0;
      vs_s1_q     <= 1'b0;
      v_samp_q    <= 1'b0;
      col_s1_q    <= '0;
      col_s2_q    <= '0;
      h_pos_q     <= '0;
      v_line_q    <= '0;
      sync_err_q  <= '0;
      ve_q        <= 1'b0;
      flags_q     <= '0;
      err_pulse_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      hs_s1_q     <= h_sync;
      hs_s2_q     <= hs_s1_q;
      vs_s1_q     <= v_sync;
      if (he) v_samp_q <= v_act;
      col_s1_q    <= {color_r, color_g, color_b};
      col_s2_q    <= col_s1_q;
      h_pos_q     <= h_pos_d;
      v_line_q    <= v_line_d;
      sync_err_q  <= sync_err_d;
      ve_q        <= ve;
      flags_q     <= flags_d;
      err_pulse_q <= any_err;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign locked      = (state_q == LOCKED);
  assign err_hperiod = flags_q[0];
  assign err_hwidth  = flags_q[1];
  assign err_vperiod = flags_q[2];
  assign err_vwidth  = flags_q[3];
  assign err_blank   = flags_q[4];
  assign err_pulse   = err_pulse_q;
  assign frame_count = frame_cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_vga_timing_checker.sv
// Directed bench for vga_timing_checker with a 14x7 mode (H 8/2/2/2, V 4/1/1/1).
module tb_vga_timing_checker;

  localparam int CW = 2;

  // clock / reset
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset_button, h_sync, v_sync, clear;
  logic [CW-1:0] color_r, color_g, color_b;
  logic          locked, err_hperiod, err_hwidth, err_vperiod, err_vwidth, err_blank, err_pulse;
  logic [15:0]   frame_count;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  vga_timing_checker #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_POL(1), .V_POL(1), .COLOR_W(CW)
  ) dut (
    .clock(clock), .reset_button(reset_button),
    .h_sync(h_sync), .v_sync(v_sync),
    .color_r(color_r), .color_g(color_g), .color_b(color_b),
    .clear(clear), .locked(locked),
    .err_hperiod(err_hperiod), .err_hwidth(err_hwidth), .err_vperiod(err_vperiod),
    .err_vwidth(err_vwidth), .err_blank(err_blank), .err_pulse(err_pulse),
    .frame_count(frame_count), .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] flags_now();
    return {err_blank, err_vwidth, err_vperiod, err_hwidth, err_hperiod};
  endfunction

  // Drives pixels p0..p1 of line li, one per cycle, starting at a falling edge and
  // returning at the falling edge after the last one. Visible pixels carry colour.
  task automatic drv_line(input int li, input bit vs_on, input int p0, input int p1,
                          input int hs_len, input int bad_pos, input logic [1:0] bad_g);
    logic vis;
    for (int p = p0; p <= p1; p++) begin
      vis     = (li >= 2) && (li <= 5) && (p >= 4) && (p <= 11);
      h_sync  = (p < hs_len);
      v_sync  = vs_on && (li == 0);
      color_r = vis ? 2'b11 : 2'b00;
      color_g = (p == bad_pos) ? bad_g : (vis ? 2'b10 : 2'b00);
      color_b = vis ? 2'b01 : 2'b00;
      @(negedge clock);
    end
  endtask

  task automatic clean_line(input int li);
    drv_line(li, 1'b1, 0, 13, 2, -1, 2'b00);
  endtask

  // Ends two edges after the vsync pixel, where lock and count changes are visible.
  task automatic frame_head();
    drv_line(0, 1'b1, 0, 2, 2, -1, 2'b00);
  endtask

  task automatic frame_rest();
    drv_line(0, 1'b1, 3, 13, 2, -1, 2'b00);
    for (int l = 1; l <= 6; l++) clean_line(l);
  endtask

  task automatic clean_frame();
    frame_head();
    frame_rest();
  endtask

  initial begin
    reset_button = 1'b0;
    h_sync = 1'b0; v_sync = 1'b0; clear = 1'b0;
    color_r = '0; color_g = '0; color_b = '0;
    repeat (2) @(negedge clock);
    check("rst_out", 32'({dbg_state, locked, flags_now(), err_pulse, frame_count}), 0);
    reset_button = 1'b1;

    // nominal frames
    clean_frame();
    check("track_unlocked", 32'(locked), 0);
    drv_line(0, 1'b1, 0, 1, 2, -1, 2'b00);
    check("lock_lat", 32'(locked), 0);
    drv_line(0, 1'b1, 2, 2, 2, -1, 2'b00);
    check("lock", 32'(locked), 1);
    check("fc_lock", 32'(frame_count), 0);
    frame_rest();
    frame_head();
    check("fc_f3", 32'(frame_count), 1);
    frame_rest();
    drv_line(0, 1'b1, 0, 1, 2, -1, 2'b00);
    check("fc_pre", 32'(frame_count), 1);
    drv_line(0, 1'b1, 2, 2, 2, -1, 2'b00);
    check("fc_f4", 32'(frame_count), 2);
    frame_rest();
    check("nom_flags", 32'(flags_now()), 0);
    check("nom_locked", 32'(locked), 1);

    // 13-clock line while locked
    frame_head();
    drv_line(0, 1'b1, 3, 13, 2, -1, 2'b00);
    clean_line(1); clean_line(2);
    drv_line(3, 1'b1, 0, 12, 2, -1, 2'b00);
    drv_line(4, 1'b1, 0, 1, 2, -1, 2'b00);
    check("hper_pre", 32'(err_pulse), 0);
    drv_line(4, 1'b1, 2, 2, 2, -1, 2'b00);
    check("hper_flag", 32'(err_hperiod), 1);
    check("hper_pulse", 32'(err_pulse), 1);
    check("hper_unlock", 32'(locked), 0);
    drv_line(4, 1'b1, 3, 3, 2, -1, 2'b00);
    check("hper_pulse_w", 32'(err_pulse), 0);
    drv_line(4, 1'b1, 4, 13, 2, -1, 2'b00);
    clean_line(5); clean_line(6);
    check("hper_only", 32'(flags_now()), 1);
    clean_frame();
    check("relock_early", 32'(locked), 0);
    frame_head();
    check("relock", 32'(locked), 1);
    check("fc_keep", 32'(frame_count), 3);

    // plain clear while locked
    clear = 1'b1;
    drv_line(0, 1'b1, 3, 3, 2, -1, 2'b00);
    clear = 1'b0;
    check("clr_flags", 32'(flags_now()), 0);
    check("clr_fc", 32'(frame_count), 0);
    check("clr_locked", 32'(locked), 1);
    drv_line(0, 1'b1, 4, 13, 2, -1, 2'b00);
    for (int l = 1; l <= 6; l++) clean_line(l);

    // 3-clock hsync pulse
    frame_head();
    check("fc_after_clr", 32'(frame_count), 1);
    drv_line(0, 1'b1, 3, 13, 2, -1, 2'b00);
    clean_line(1);
    drv_line(2, 1'b1, 0, 13, 3, -1, 2'b00);
    check("hwid_flag", 32'(err_hwidth), 1);
    check("hwid_hper", 32'(err_hperiod), 0);
    check("hwid_unlock", 32'(locked), 0);
    for (int l = 3; l <= 6; l++) clean_line(l);

    // colour during blanking
    clean_frame();
    frame_head();
    check("blank_lock", 32'(locked), 1);
    drv_line(0, 1'b1, 3, 13, 2, -1, 2'b00);
    clean_line(1);
    drv_line(2, 1'b1, 0, 13, 2, 4, 2'b01);
    check("blank_vis_ok", 32'(err_blank), 0);
    check("blank_vis_lock", 32'(locked), 1);
    drv_line(3, 1'b1, 0, 1, 2, 0, 2'b01);
    check("blank_pre", 32'(err_blank), 0);
    drv_line(3, 1'b1, 2, 2, 2, -1, 2'b00);
    check("blank_flag", 32'(err_blank), 1);
    check("blank_pulse", 32'(err_pulse), 1);
    drv_line(3, 1'b1, 3, 13, 2, -1, 2'b00);
    for (int l = 4; l <= 6; l++) clean_line(l);

    // vsync missing for one frame
    clean_frame();
    clean_frame();
    check("vper_lock", 32'(locked), 1);
    drv_line(0, 1'b0, 0, 1, 2, -1, 2'b00);
    check("vper_pre", 32'(err_vperiod), 0);
    drv_line(0, 1'b0, 2, 2, 2, -1, 2'b00);
    check("vper_flag", 32'(err_vperiod), 1);
    check("vper_unlock", 32'(locked), 0);
    drv_line(0, 1'b0, 3, 13, 2, -1, 2'b00);
    for (int l = 1; l <= 6; l++) clean_line(l);

    // error in the same cycle as clear
    clean_frame();
    clean_frame();
    frame_head();
    check("fc_f16", 32'(frame_count), 2);
    drv_line(0, 1'b1, 3, 13, 2, -1, 2'b00);
    clean_line(1); clean_line(2);
    drv_line(3, 1'b1, 0, 12, 2, -1, 2'b00);
    drv_line(4, 1'b1, 0, 1, 2, -1, 2'b00);
    clear = 1'b1;
    drv_line(4, 1'b1, 2, 2, 2, -1, 2'b00);
    clear = 1'b0;
    check("clr_err_flags", 32'(flags_now()), 1);
    check("clr_err_fc", 32'(frame_count), 0);
    drv_line(4, 1'b1, 3, 13, 2, -1, 2'b00);
    clean_line(5); clean_line(6);

    // reset mid-frame
    clean_frame();
    clean_frame();
    frame_head();
    check("fc_pre_rst", 32'(frame_count), 1);
    drv_line(0, 1'b1, 3, 13, 2, -1, 2'b00);
    clean_line(1); clean_line(2);
    drv_line(3, 1'b1, 0, 5, 2, -1, 2'b00);
    reset_button = 1'b0;
    #1;
    check("rst_mid", 32'({locked, flags_now(), err_pulse, frame_count}), 0);
    drv_line(3, 1'b1, 6, 8, 2, -1, 2'b00);
    reset_button = 1'b1;
    drv_line(3, 1'b1, 9, 13, 2, -1, 2'b00);
    for (int l = 4; l <= 6; l++) clean_line(l);
    frame_head();
    check("rst_relock_early", 32'(locked), 0);
    frame_rest();
    frame_head();
    check("rst_relock", 32'(locked), 1);
    check("rst_flags", 32'(flags_now()), 0);
    frame_rest();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
